sayac_mem_responder: RTL and testbench

//  Memory-side responder for the SAYAC CPU rd/wr/ready bus. Accepts one read or write
//  per transaction, inserts WAIT_CYCLES wait states, then pulses ready for one cycle.

---
 rtl/sayac_mem_responder.sv | 113 +++++++++++
 tb/tb_sayac_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sayac_mem_responder.sv
// Memory-side responder for the SAYAC rd/wr/ready bus: one transaction at a time,
// WAIT_CYCLES wait states, one-cycle ready pulse. Optional macro: SAYAC_MEM_OOR_ERR_EN.
module sayac_mem_responder #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADR_WIDTH     = 16,
  parameter int unsigned MEM_ADR_WIDTH = 10,
  parameter int unsigned WAIT_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADR_WIDTH-1:0]  address_bus,
  inout  logic [DATA_WIDTH-1:0] data_bus,
  input  logic                  rd,
  input  logic                  wr,
  output logic                  ready
`ifdef SAYAC_MEM_OOR_ERR_EN
  ,
  output logic                  oor_err
`endif
);

  localparam int unsigned DEPTH = 1 << MEM_ADR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                   state;
  logic [7:0]               cnt;
  logic [MEM_ADR_WIDTH-1:0] addr_q;
  logic                     op_wr;
  logic                     oor_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic                     oor_in;
  logic                     accept;
  logic                     commit;

`ifdef SAYAC_MEM_OOR_ERR_EN
  assign oor_in = (address_bus >> MEM_ADR_WIDTH) != '0;
`else
  // Upper address bits simply alias onto the implemented RAM.
  logic unused_hi;
  assign unused_hi = ^address_bus[ADR_WIDTH-1:MEM_ADR_WIDTH];
  assign oor_in    = 1'b0;
`endif

  assign accept = (state == IDLE) && (rd || wr);
  assign commit = (state == BUSY) && (cnt == '0) && op_wr && !oor_q;

  // rd and wr together count as a write, so op_wr alone decides the drive.
  assign data_bus = (!op_wr && state != IDLE) ? rdata_q : 'z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ready   <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      op_wr   <= 1'b0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
`ifdef SAYAC_MEM_OOR_ERR_EN
      oor_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (rd || wr) begin
            addr_q  <= address_bus[MEM_ADR_WIDTH-1:0];
            op_wr   <= wr;
            oor_q   <= oor_in;
            wdata_q <= data_bus;
            cnt     <= 8'(WAIT_CYCLES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= RESP;
            ready <= 1'b1;
`ifdef SAYAC_MEM_OOR_ERR_EN
            oor_err <= oor_q;
`endif
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          ready <= 1'b0;
`ifdef SAYAC_MEM_OOR_ERR_EN
          oor_err <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM has no reset; commit depends on state, so a reset before RESP drops the write.
  always_ff @(posedge clk) begin
    if (commit)
      mem[addr_q] <= wdata_q;
    if (accept)
      rdata_q <= oor_in ? '0 : mem[address_bus[MEM_ADR_WIDTH-1:0]];
  end

endmodule

// File: tb/tb_sayac_mem_responder.sv
// Self-checking bench for sayac_mem_responder: directed and random transactions against
// an address-keyed memory model; a second instance covers WAIT_CYCLES=0.
module tb_sayac_mem_responder;

  localparam int unsigned W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] address_bus;
  wire  [15:0] data_bus;
  logic        rd, wr, ready;
  logic        tb_en;
  logic [15:0] tb_data;
  assign data_bus = tb_en ? tb_data : 'z;

  logic [15:0] address0;
  wire  [15:0] data0;
  logic        rd0, wr0, ready0;
  logic        en0;
  logic [15:0] tdata0;
  assign data0 = en0 ? tdata0 : 'z;

`ifdef SAYAC_MEM_OOR_ERR_EN
  logic oor_err, oor0;
`endif

  sayac_mem_responder #(
    .DATA_WIDTH(16), .ADR_WIDTH(16), .MEM_ADR_WIDTH(10), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst), .address_bus(address_bus), .data_bus(data_bus),
    .rd(rd), .wr(wr), .ready(ready)
`ifdef SAYAC_MEM_OOR_ERR_EN
    , .oor_err(oor_err)
`endif
  );

  sayac_mem_responder #(
    .DATA_WIDTH(16), .ADR_WIDTH(16), .MEM_ADR_WIDTH(10), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .address_bus(address0), .data_bus(data0),
    .rd(rd0), .wr(wr0), .ready(ready0)
`ifdef SAYAC_MEM_OOR_ERR_EN
    , .oor_err(oor0)
`endif
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [15:0] model [int unsigned];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oor(input logic [15:0] a);
`ifdef SAYAC_MEM_OOR_ERR_EN
    return a >= 16'd1024;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] mdl_read(input logic [15:0] a);
    if (is_oor(a)) return 16'h0000;
    return model[32'(a) % 1024];
  endfunction

  task automatic mdl_write(input logic [15:0] a, input logic [15:0] d);
    if (!is_oor(a)) model[32'(a) % 1024] = d;
  endtask

  // Full transaction on the WAIT_CYCLES=W instance. For writes the bench keeps driving
  // d, so any responder drive would corrupt the bus value seen.
  task automatic txn(input string tag, input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d, input bit hold);
    logic [15:0] exp;
    int unsigned n;
    exp = w ? d : mdl_read(a);
    @(negedge clk);
    address_bus = a; rd = r; wr = w; tb_en = w; tb_data = d;
    @(posedge clk); #1;
    chk({tag, "/bus_e0"}, 32'(data_bus), 32'(exp));
    chk({tag, "/ready_e0"}, 32'(ready), 32'd0);
    if (!hold) begin
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
    end
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (ready || n >= 20) break;
      chk({tag, "/bus_wait"}, 32'(data_bus), 32'(exp));
    end
    chk({tag, "/latency"}, 32'(n), 32'(W + 1));
    chk({tag, "/bus_ready"}, 32'(data_bus), 32'(exp));
`ifdef SAYAC_MEM_OOR_ERR_EN
    chk({tag, "/oor_err"}, 32'(oor_err), 32'(is_oor(a)));
`endif
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/ready_fall"}, 32'(ready), 32'd0);
    tb_en = 1'b0;
    if (w) mdl_write(a, d);
  endtask

  task automatic txn0(input string tag, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] exp);
    @(negedge clk);
    address0 = a; rd0 = !w; wr0 = w; en0 = w; tdata0 = d;
    @(posedge clk); #1;
    chk({tag, "/bus_e0"}, 32'(data0), 32'(exp));
    chk({tag, "/ready_e0"}, 32'(ready0), 32'd0);
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/ready_e1"}, 32'(ready0), 32'd1);
    chk({tag, "/bus_ready"}, 32'(data0), 32'(exp));
`ifdef SAYAC_MEM_OOR_ERR_EN
    chk({tag, "/oor_err"}, 32'(oor0), 32'd0);
`endif
    @(posedge clk); #1;
    chk({tag, "/ready_fall"}, 32'(ready0), 32'd0);
    en0 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a, d;

    // Reset: bench drives 0 onto the bus so any responder drive would show.
    rst = 1'b0; rd = 1'b0; wr = 1'b0; address_bus = '0; tb_en = 1'b1; tb_data = '0;
    rd0 = 1'b0; wr0 = 1'b0; address0 = '0; en0 = 1'b1; tdata0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/ready", 32'(ready), 32'd0);
    chk("reset/bus", 32'(data_bus), 32'd0);
    chk("reset/ready0", 32'(ready0), 32'd0);
    chk("reset/bus0", 32'(data0), 32'd0);
`ifdef SAYAC_MEM_OOR_ERR_EN
    chk("reset/oor_err", 32'(oor_err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1; tb_en = 1'b0; en0 = 1'b0;

    txn("w0_888", 1'b0, 1'b1, 16'd0, 16'd888, 1'b0);
    txn("r0_888", 1'b1, 1'b0, 16'd0, 16'd0, 1'b0);

    txn("w1", 1'b0, 1'b1, 16'd1, 16'd111, 1'b0);
    txn("w2", 1'b0, 1'b1, 16'd2, 16'd222, 1'b0);
    txn("w3", 1'b0, 1'b1, 16'd3, 16'd333, 1'b0);
    txn("r1_hold", 1'b1, 1'b0, 16'd1, 16'd0, 1'b1);
    txn("r2_hold", 1'b1, 1'b0, 16'd2, 16'd0, 1'b1);
    txn("r3_hold", 1'b1, 1'b0, 16'd3, 16'd0, 1'b1);

    txn("w0_444", 1'b0, 1'b1, 16'd0, 16'd444, 1'b0);
    txn("r1024", 1'b1, 1'b0, 16'd1024, 16'd0, 1'b0);

    // Old contents chosen so a stray drive of them cannot blend into 16'h1234.
    txn("w9_edcb", 1'b0, 1'b1, 16'd9, 16'hEDCB, 1'b0);
    txn("rdwr9", 1'b1, 1'b1, 16'd9, 16'h1234, 1'b0);
    txn("r9", 1'b1, 1'b0, 16'd9, 16'd0, 1'b0);

    // Reset during BUSY of write 5<-777: write must be dropped.
    txn("w5_555", 1'b0, 1'b1, 16'd5, 16'd555, 1'b0);
    @(negedge clk);
    address_bus = 16'd5; wr = 1'b1; tb_en = 1'b1; tb_data = 16'd777;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("wabort/ready", 32'(ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("wabort/ready_held", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b1; tb_en = 1'b0;

    // Reset during BUSY of a read: bus must be released at once.
    @(negedge clk);
    address_bus = 16'd5; rd = 1'b1;
    @(posedge clk); #1;
    chk("rabort/bus_e0", 32'(data_bus), 32'd555);
    @(negedge clk);
    rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; tb_en = 1'b1; tb_data = 16'h0000;
    #1;
    chk("rabort/bus_released", 32'(data_bus), 32'd0);
    chk("rabort/ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b1; tb_en = 1'b0;
    txn("r5_old", 1'b1, 1'b0, 16'd5, 16'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a = a + 16'(1024 * $urandom_range(1, 3));
      d = 16'($urandom);
      if (!model.exists(32'(a) % 1024) || $urandom_range(0, 1) == 1)
        txn("rand_w", 1'b0, 1'b1, a, d, bit'($urandom_range(0, 1)));
      else
        txn("rand_r", 1'b1, 1'b0, a, 16'd0, bit'($urandom_range(0, 1)));
    end

    txn0("z_w7", 1'b1, 16'd7, 16'h0BEE, 16'h0BEE);
    txn0("z_r7", 1'b0, 16'd7, 16'h0000, 16'h0BEE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
